lfsr_checker: RTL and testbench

Downstream consumer of the 4-bit LFSR stage. Samples the LFSR output word stream, self-synchronises to the sequence, and declares lock after a run of correct transitions. Once locked, it counts every word that deviates from the predicted sequence and drops lock on sustained mismatch. It provides the pass/fail observability point for the LFSR and for any link that carries its pattern.

---
 rtl/lfsr_pkg.sv | 16 +
 rtl/sat_counter.sv | 23 ++
 rtl/lfsr_checker.sv | 118 +++++++++++
 tb/tb_lfsr_checker.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/lfsr_pkg.sv
// Shared 4-bit LFSR definitions (x^4+x^3+1, period 15).
// Used by the LFSR stage, its checker and future scramblers.
package lfsr_pkg;

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_e;

  localparam logic [3:0] LFSR_ZERO = 4'b0000;

  function automatic logic [3:0] lfsr4_next(input logic [3:0] x);
    return {x[2:0], x[3] ^ x[2]};
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Parameterised-width counter with saturating increment
// and synchronous clear (clear has priority).
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && !(&count)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/lfsr_checker.sv
// Self-synchronising checker for the 4-bit LFSR word stream.
// Define LFSR_CHECKER_STATS_EN to build the locked word counter.
import lfsr_pkg::*;

module lfsr_checker #(
  parameter int LOCK_COUNT = 4,
  parameter int LOSS_COUNT = 3,
  parameter int ERR_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       data_in,
  input  logic             data_valid,
  input  logic             clear,
  output logic             locked,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_count,
  output logic [31:0]      word_count
);

  localparam logic [3:0] LOCK_W = 4'(LOCK_COUNT);
  localparam logic [3:0] LOSS_W = 4'(LOSS_COUNT);

  state_e     state;
  logic [3:0] prev;
  logic [3:0] expected;
  logic [3:0] match_cnt;
  logic [3:0] miss_cnt;
  logic       prev_ok;

  logic       hit;
  logic       miss;
  logic [3:0] match_nxt;
  logic [3:0] miss_nxt;

  assign hit = (data_in == lfsr4_next(prev))
            && (data_in != LFSR_ZERO);
  // expected is never zero once locked, so a zero word always misses
  assign miss = data_valid && (state == LOCKED)
             && (data_in != expected);
  assign match_nxt = match_cnt + 4'd1;
  assign miss_nxt  = miss_cnt + 4'd1;
  assign locked    = (state == LOCKED);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= HUNT;
      prev      <= '0;
      prev_ok   <= 1'b0;
      expected  <= '0;
      match_cnt <= '0;
      miss_cnt  <= '0;
      err_pulse <= 1'b0;
    end else begin
      err_pulse <= miss;
      if (data_valid) begin
        unique case (state)
          HUNT: begin
            prev    <= data_in;
            prev_ok <= 1'b1;
            if (prev_ok) begin
              if (!hit) begin
                match_cnt <= '0;
              end else if (match_nxt == LOCK_W) begin
                state     <= LOCKED;
                expected  <= lfsr4_next(data_in);
                match_cnt <= '0;
                miss_cnt  <= '0;
              end else begin
                match_cnt <= match_nxt;
              end
            end
          end
          LOCKED: begin
            expected <= lfsr4_next(expected);
            if (!miss) begin
              miss_cnt <= '0;
            end else if (miss_nxt == LOSS_W) begin
              state     <= HUNT;
              miss_cnt  <= '0;
              match_cnt <= '0;
              prev      <= data_in;
              prev_ok   <= 1'b1;
            end else begin
              miss_cnt <= miss_nxt;
            end
          end
          default: ;
        endcase
      end
    end
  end

  sat_counter #(
    .W(ERR_W)
  ) u_err_cnt (
    .clk  (clk),
    .rst_n(reset),
    .clr  (clear),
    .inc  (miss),
    .count(err_count)
  );

`ifdef LFSR_CHECKER_STATS_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      word_count <= '0;
    end else if (clear) begin
      word_count <= '0;
    end else if (data_valid && (state == LOCKED)) begin
      word_count <= word_count + 32'd1;
    end
  end
`else
  assign word_count = '0;
`endif

endmodule

// File: tb/tb_lfsr_checker.sv
// Directed + randomized bench for lfsr_checker against a behavioural model.
// Two instances: defaults, and ERR_W=4 / LOSS_COUNT=15 for saturation.
module tb_lfsr_checker;

  logic        clk   = 1'b0;
  logic        reset = 1'b1;
  logic        dv    = 1'b0;
  logic        clr   = 1'b0;
  logic [3:0]  din   = 4'd0;

  logic        lk0, ep0, lk1, ep1;
  logic [15:0] ec0;
  logic [3:0]  ec1;
  logic [31:0] wc0, wc1;

  lfsr_checker #(
    .LOCK_COUNT(4), .LOSS_COUNT(3), .ERR_W(16)
  ) dut0 (
    .clk(clk), .reset(reset), .data_in(din), .data_valid(dv),
    .clear(clr), .locked(lk0), .err_pulse(ep0),
    .err_count(ec0), .word_count(wc0)
  );

  lfsr_checker #(
    .LOCK_COUNT(4), .LOSS_COUNT(15), .ERR_W(4)
  ) dut1 (
    .clk(clk), .reset(reset), .data_in(din), .data_valid(dv),
    .clear(clr), .locked(lk1), .err_pulse(ep1),
    .err_count(ec1), .word_count(wc1)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cur;

  int     p_lock [2] = '{4, 4};
  int     p_loss [2] = '{3, 15};
  longint p_emax [2] = '{65535, 15};

  int     m_lk [2], m_prev [2], m_run [2];
  int     m_miss [2], m_exp [2], m_pulse [2];
  longint m_err [2], m_wc [2];

  function automatic int nxt(input int x);
    return ((x * 2) % 16) | (((x >> 3) ^ (x >> 2)) & 1);
  endfunction

  function automatic int bad_of(input int c);
    return (c == 15) ? 14 : 15;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_lk[k] = 0; m_prev[k] = -1; m_run[k] = 0;
      m_miss[k] = 0; m_exp[k] = 0; m_pulse[k] = 0;
      m_err[k] = 0; m_wc[k] = 0;
    end
  endtask

  task automatic model_step(input int v, input int w, input int c);
    for (int k = 0; k < 2; k++) begin
      m_pulse[k] = 0;
      if (v != 0) begin
        if (m_lk[k] != 0) begin
          m_wc[k] = (m_wc[k] + 1) % 64'h1_0000_0000;
          if (w == m_exp[k]) m_miss[k] = 0;
          else begin
            m_pulse[k] = 1;
            if (m_err[k] < p_emax[k]) m_err[k]++;
            m_miss[k]++;
          end
          m_exp[k] = nxt(m_exp[k]);
          if (m_miss[k] == p_loss[k]) begin
            m_lk[k] = 0; m_run[k] = 0;
            m_prev[k] = w; m_miss[k] = 0;
          end
        end else if (m_prev[k] < 0) begin
          m_prev[k] = w;
        end else begin
          if (w == nxt(m_prev[k]) && w != 0) m_run[k]++;
          else m_run[k] = 0;
          m_prev[k] = w;
          if (m_run[k] == p_lock[k]) begin
            m_lk[k] = 1; m_exp[k] = nxt(w);
            m_run[k] = 0; m_miss[k] = 0;
          end
        end
      end
      if (c != 0) begin
        m_err[k] = 0;
        m_wc[k]  = 0;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_all();
    longint w0, w1;
`ifdef LFSR_CHECKER_STATS_EN
    w0 = m_wc[0]; w1 = m_wc[1];
`else
    w0 = 0; w1 = 0;
`endif
    chk("locked0", {63'b0, lk0}, m_lk[0]);
    chk("pulse0", {63'b0, ep0}, m_pulse[0]);
    chk("errcnt0", {48'b0, ec0}, m_err[0]);
    chk("wcount0", {32'b0, wc0}, w0);
    chk("locked1", {63'b0, lk1}, m_lk[1]);
    chk("pulse1", {63'b0, ep1}, m_pulse[1]);
    chk("errcnt1", {60'b0, ec1}, m_err[1]);
    chk("wcount1", {32'b0, wc1}, w1);
  endtask

  task automatic step(input int v, input int w, input int c);
    dv  = v[0];
    din = w[3:0];
    clr = c[0];
    @(posedge clk);
    model_step(v, w, c);
    #1;
    check_all();
  endtask

  initial begin
    int bad, v, r, w, c;
    model_reset();
    #1 reset = 1'b0;
    #1 check_all();
    #18 reset = 1'b1;

    // clean stream from 0001
    cur = 1;
    for (int i = 0; i < 50; i++) begin
      step(1, cur, 0);
      cur = nxt(cur);
      if (i == 3) chk("lock_4th", {63'b0, lk0}, 0);
      if (i == 4) chk("lock_5th", {63'b0, lk0}, 1);
    end
    chk("clean_err", {48'b0, ec0}, 0);
`ifdef LFSR_CHECKER_STATS_EN
    chk("clean_words", {32'b0, wc0}, 45);
`else
    chk("clean_words", {32'b0, wc0}, 0);
`endif

    // single error
    step(1, bad_of(cur), 0);
    cur = nxt(cur);
    chk("single_pulse", {63'b0, ep0}, 1);
    chk("single_cnt", {48'b0, ec0}, 1);
    chk("single_lock", {63'b0, lk0}, 1);
    step(1, cur, 0);
    cur = nxt(cur);
    chk("after_pulse", {63'b0, ep0}, 0);
    chk("after_cnt", {48'b0, ec0}, 1);

    // loss of lock on three zero words, then relock
    step(0, 0, 1);
    chk("clear_cnt", {48'b0, ec0}, 0);
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 0);
      cur = nxt(cur);
    end
    chk("loss_cnt", {48'b0, ec0}, 3);
    chk("loss_lock", {63'b0, lk0}, 0);
    chk("hold_lock1", {63'b0, lk1}, 1);
    for (int i = 0; i < 5; i++) begin
      step(1, cur, 0);
      cur = nxt(cur);
      if (i == 3) chk("relock_4th", {63'b0, lk0}, 0);
      if (i == 4) chk("relock_5th", {63'b0, lk0}, 1);
    end

    // gapped valid after a fresh reset
    reset = 1'b0;
    model_reset();
    #4 reset = 1'b1;
    cur = 9;
    for (int i = 0; i < 10; i++) begin
      if (i % 2 == 0) begin
        step(1, cur, 0);
        cur = nxt(cur);
      end else begin
        step(0, $urandom_range(0, 15), 0);
      end
      if (i == 6) chk("gap_4th", {63'b0, lk0}, 0);
      if (i == 8) chk("gap_5th", {63'b0, lk0}, 1);
    end
    chk("gap_err", {48'b0, ec0}, 0);

    // saturation and clear coincident with an error
    for (int i = 0; i < 20; i++) begin
      step(1, bad_of(cur), 0);
      cur = nxt(cur);
      step(1, cur, 0);
      cur = nxt(cur);
    end
    chk("sat_cnt", {60'b0, ec1}, 15);
    chk("sat_lock", {63'b0, lk1}, 1);
    chk("nosat_cnt", {48'b0, ec0}, 20);
    step(1, bad_of(cur), 1);
    cur = nxt(cur);
    chk("clrwin_cnt", {60'b0, ec1}, 0);
    chk("clrwin_pulse", {63'b0, ep1}, 1);

    // randomized stream
    for (int i = 0; i < 400; i++) begin
      v = ($urandom_range(0, 3) != 0) ? 1 : 0;
      r = $urandom_range(0, 9);
      w = (r < 7) ? cur : (r < 8) ? 0 : $urandom_range(0, 15);
      c = ($urandom_range(0, 31) == 0) ? 1 : 0;
      step(v, w, c);
      if (v != 0) cur = nxt(cur);
    end

    // asynchronous reset while locked with two errors
    step(0, 0, 1);
    for (int i = 0; i < 6; i++) begin
      step(1, cur, 0);
      cur = nxt(cur);
    end
    bad = bad_of(cur);
    step(1, bad, 0);
    cur = nxt(cur);
    step(1, cur, 0);
    cur = nxt(cur);
    step(1, bad_of(cur), 0);
    cur = nxt(cur);
    chk("pre_rst_cnt", {48'b0, ec0}, 2);
    chk("pre_rst_lock", {63'b0, lk0}, 1);
    #3 reset = 1'b0;
    #1;
    chk("rst_lock0", {63'b0, lk0}, 0);
    chk("rst_pulse0", {63'b0, ep0}, 0);
    chk("rst_cnt0", {48'b0, ec0}, 0);
    chk("rst_wc0", {32'b0, wc0}, 0);
    chk("rst_lock1", {63'b0, lk1}, 0);
    chk("rst_cnt1", {60'b0, ec1}, 0);
    model_reset();
    #2 reset = 1'b1;
    cur = 6;
    for (int i = 0; i < 5; i++) begin
      step(1, cur, 0);
      cur = nxt(cur);
      if (i == 3) chk("seed_4th", {63'b0, lk0}, 0);
      if (i == 4) chk("seed_5th", {63'b0, lk0}, 1);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
